// File: rtl/attention_sequencer_if.sv
// Handshake bundle between an attention job requester, the compute engines and the
// attention_sequencer.
//
// Signals:
//   start, abort          job request / cancel (requester -> sequencer)
//   cfg_layers            layers to run (0 treated as 1, clamped to MAX_LAYERS)
//   cfg_timeout           per-stage watchdog limit, 0 disables
//   qkv/qk/mlp_start      single-cycle engine start pulses (sequencer -> engines)
//   qkv/qk/mlp_done       engine completion (engines -> sequencer)
//   fb_sel                engine input select: 0 external x, 1 previous-layer buffer
//   capture               load MLP output into the layer buffer
//   layer_idx             current layer
//   busy, done            job in flight / single-cycle job-complete pulse
//   err, err_stage        sticky watchdog error and stage code (1 QKV, 2 QK, 3 MLP)
//
// Modports: master = requester/engine side, slave = sequencer side.
interface attention_sequencer_if #(
  parameter int unsigned MAX_LAYERS = 4,
  parameter int unsigned TMO_W      = 16
) ();
  localparam int unsigned LAYER_W = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;

  logic               start;
  logic               abort;
  logic [LAYER_W:0]   cfg_layers;
  logic [TMO_W-1:0]   cfg_timeout;
  logic               qkv_start;
  logic               qk_start;
  logic               mlp_start;
  logic               qkv_done;
  logic               qk_done;
  logic               mlp_done;
  logic               fb_sel;
  logic               capture;
  logic [LAYER_W-1:0] layer_idx;
  logic               busy;
  logic               done;
  logic               err;
  logic [1:0]         err_stage;

  modport master (
    output start, abort, cfg_layers, cfg_timeout, qkv_done, qk_done, mlp_done,
    input  qkv_start, qk_start, mlp_start, fb_sel, capture, layer_idx, busy, done, err,
           err_stage
  );

  modport slave (
    input  start, abort, cfg_layers, cfg_timeout, qkv_done, qk_done, mlp_done,
    output qkv_start, qk_start, mlp_start, fb_sel, capture, layer_idx, busy, done, err,
           err_stage
  );
endinterface

// File: rtl/attention_sequencer.sv
// Attention-layer job sequencer. Runs up to MAX_LAYERS encoder layers per job, each as
// QKV -> QK -> softmax settle (SMX_CYC cycles) -> AXV (1 cycle) -> MLP, feeding each
// layer's output back as the next layer's input.
//
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus_io   attention_sequencer_if.slave (job control, engine handshakes, status)
//
// All outputs are registered. Optional per-stage watchdog is enabled by defining
// ATTN_SEQ_WATCHDOG_EN; without it stages wait indefinitely and err/err_stage read 0.
module attention_sequencer #(
  parameter int unsigned MAX_LAYERS = 4,
  parameter int unsigned TMO_W      = 16,
  parameter int unsigned SMX_CYC    = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  attention_sequencer_if.slave bus_io
);

  localparam int unsigned LAYER_W   = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
  localparam int unsigned LayerCntW = LAYER_W + 1;
  localparam int unsigned SmxW      = (SMX_CYC > 1) ? $clog2(SMX_CYC) : 1;

  typedef enum logic [3:0] {
    StIdle,
    StQkv,
    StQk,
    StSmx,
    StAxv,
    StMlp,
    StLnext,
    StDone,
    StErr
  } state_e;

  state_e               state_q, state_d;
  logic [LayerCntW-1:0] layers_q, layers_d;
  logic [LAYER_W-1:0]   layer_idx_q, layer_idx_d;
  logic [SmxW-1:0]      smx_cnt_q, smx_cnt_d;
  logic                 fb_sel_q, fb_sel_d;
  logic                 qkv_start_q, qkv_start_d;
  logic                 qk_start_q, qk_start_d;
  logic                 mlp_start_q, mlp_start_d;
  logic                 capture_q, capture_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 accept;
  logic                 last_layer;
  logic                 wdog_expire;
  logic [LayerCntW-1:0] layers_clamped;

  assign accept     = (state_q == StIdle) && bus_io.start;
  assign last_layer = (LayerCntW'(layer_idx_q) + LayerCntW'(1)) == layers_q;

  // 0 layers still runs one; oversize requests saturate at the hardware limit.
  always_comb begin
    if (bus_io.cfg_layers == '0) begin
      layers_clamped = LayerCntW'(1);
    end else if (bus_io.cfg_layers > LayerCntW'(MAX_LAYERS)) begin
      layers_clamped = LayerCntW'(MAX_LAYERS);
    end else begin
      layers_clamped = bus_io.cfg_layers;
    end
  end

  always_comb begin
    state_d     = state_q;
    layers_d    = layers_q;
    layer_idx_d = layer_idx_q;
    smx_cnt_d   = smx_cnt_q;
    fb_sel_d    = fb_sel_q;

    if ((state_q != StIdle) && bus_io.abort) begin
      // Abort beats any engine done arriving in the same cycle.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d     = StQkv;
            layers_d    = layers_clamped;
            layer_idx_d = '0;
            fb_sel_d    = 1'b0;
          end
        end
        StQkv: begin
          if (bus_io.qkv_done) begin
            state_d = StQk;
          end else if (wdog_expire) begin
            state_d = StErr;
          end
        end
        StQk: begin
          if (bus_io.qk_done) begin
            state_d   = StSmx;
            smx_cnt_d = '0;
          end else if (wdog_expire) begin
            state_d = StErr;
          end
        end
        StSmx: begin
          if (smx_cnt_q == SmxW'(SMX_CYC - 1)) begin
            state_d = StAxv;
          end else begin
            smx_cnt_d = smx_cnt_q + SmxW'(1);
          end
        end
        StAxv: begin
          state_d = StMlp;
        end
        StMlp: begin
          if (bus_io.mlp_done) begin
            if (last_layer) begin
              state_d = StDone;
            end else begin
              state_d     = StLnext;
              layer_idx_d = layer_idx_q + LAYER_W'(1);
            end
          end else if (wdog_expire) begin
            state_d = StErr;
          end
        end
        StLnext: begin
          state_d  = StQkv;
          fb_sel_d = 1'b1;
        end
        StDone: begin
          state_d = StIdle;
        end
        StErr: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    if (state_d == StIdle) begin
      layer_idx_d = '0;
      fb_sel_d    = 1'b0;
    end
  end

  // Registered outputs are decoded from the transition so they line up with the state.
  always_comb begin
    qkv_start_d = (state_d == StQkv) && (state_q != StQkv);
    qk_start_d  = (state_d == StQk) && (state_q != StQk);
    mlp_start_d = (state_d == StMlp) && (state_q != StMlp);
    capture_d   = (state_d == StLnext) || (state_d == StDone);
    done_d      = (state_d == StDone);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      layers_q    <= '0;
      layer_idx_q <= '0;
      smx_cnt_q   <= '0;
      fb_sel_q    <= 1'b0;
      qkv_start_q <= 1'b0;
      qk_start_q  <= 1'b0;
      mlp_start_q <= 1'b0;
      capture_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      layers_q    <= layers_d;
      layer_idx_q <= layer_idx_d;
      smx_cnt_q   <= smx_cnt_d;
      fb_sel_q    <= fb_sel_d;
      qkv_start_q <= qkv_start_d;
      qk_start_q  <= qk_start_d;
      mlp_start_q <= mlp_start_d;
      capture_q   <= capture_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

`ifdef ATTN_SEQ_WATCHDOG_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [TMO_W-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;
  logic [1:0]       err_stage_q, err_stage_d;
  logic             waiting;

  assign waiting     = (state_q == StQkv) || (state_q == StQk) || (state_q == StMlp);
  // Expiry only matters when done is absent; the stage logic checks done first.
  assign wdog_expire = (tmo_q != '0) && ((wdog_q + TMO_W'(1)) == tmo_q);

  always_comb begin
    tmo_d       = tmo_q;
    wdog_d      = wdog_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;

    if (accept) begin
      tmo_d       = bus_io.cfg_timeout;
      err_d       = 1'b0;
      err_stage_d = 2'd0;
    end

    if (qkv_start_d || qk_start_d || mlp_start_d) begin
      wdog_d = '0;
    end else if (waiting) begin
      wdog_d = wdog_q + TMO_W'(1);
    end

    if ((state_d == StErr) && (state_q != StErr)) begin
      err_d = 1'b1;
      unique case (state_q)
        StQkv:   err_stage_d = 2'd1;
        StQk:    err_stage_d = 2'd2;
        default: err_stage_d = 2'd3;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q       <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      err_stage_q <= 2'd0;
    end else begin
      tmo_q       <= tmo_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign bus_io.err       = err_q;
  assign bus_io.err_stage = err_stage_q;
`else
  logic unused_cfg_timeout;

  assign wdog_expire        = 1'b0;
  assign unused_cfg_timeout = ^bus_io.cfg_timeout;
  assign bus_io.err         = 1'b0;
  assign bus_io.err_stage   = 2'd0;
`endif

  assign bus_io.qkv_start = qkv_start_q;
  assign bus_io.qk_start  = qk_start_q;
  assign bus_io.mlp_start = mlp_start_q;
  assign bus_io.fb_sel    = fb_sel_q;
  assign bus_io.capture   = capture_q;
  assign bus_io.layer_idx = layer_idx_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;

endmodule

// File: tb/tb_attention_sequencer.sv
// Directed bench for attention_sequencer with zero-wait engine model and a pulse
// scoreboard: expected start/capture/done pulses are queued when a job is launched and
// popped as the DUT emits them.
module tb_attention_sequencer;
  localparam int unsigned MaxLayers = 4;
  localparam int unsigned TmoW      = 16;
  localparam int unsigned SmxCyc    = 2;

  typedef struct {
    int         cyc;
    logic [4:0] vec;   // {qkv_start, qk_start, mlp_start, capture, done}
    logic [1:0] layer;
    logic       fb;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  attention_sequencer_if #(.MAX_LAYERS(MaxLayers), .TMO_W(TmoW)) bus ();

  attention_sequencer #(
    .MAX_LAYERS(MaxLayers),
    .TMO_W     (TmoW),
    .SMX_CYC   (SmxCyc)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  ev_t  exp_q[$];
  int   cyc;
  int   checks;
  int   errors;
  logic qkv_p, qk_p, mlp_p;
  logic hold_qk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: engines answer one cycle after their start pulse, then outputs are
  // compared against the scoreboard at the falling edge.
  task automatic tick();
    logic [4:0] vec;
    ev_t        e;
    @(posedge clk);
    cyc++;
    #1;
    bus.qkv_done = qkv_p;
    bus.qk_done  = qk_p & ~hold_qk;
    bus.mlp_done = mlp_p;
    qkv_p = bus.qkv_start;
    qk_p  = bus.qk_start;
    mlp_p = bus.mlp_start;
    @(negedge clk);
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check("missed_pulse_cycle", 32'(cyc), 32'(e.cyc));
    end
    vec = {bus.qkv_start, bus.qk_start, bus.mlp_start, bus.capture, bus.done};
    if (vec != 5'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(vec), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("pulse_vec", 32'(vec), 32'(e.vec));
        check("pulse_layer_idx", 32'(bus.layer_idx), 32'(e.layer));
        check("pulse_fb_sel", 32'(bus.fb_sel), 32'(e.fb));
      end
    end
  endtask

  task automatic push_layers(input int t0, input int eff);
    for (int l = 0; l < eff; l++) begin
      int         b;
      logic       lst;
      logic [1:0] li;
      logic       fb;
      b   = t0 + 10 * l;
      lst = (l == eff - 1);
      li  = 2'(l);
      fb  = (l > 0);
      exp_q.push_back('{b + 1, 5'b10000, li, fb});
      exp_q.push_back('{b + 3, 5'b01000, li, fb});
      exp_q.push_back('{b + 8, 5'b00100, li, fb});
      exp_q.push_back('{b + 10, lst ? 5'b00011 : 5'b00010, lst ? li : 2'(l + 1), fb});
    end
  endtask

  task automatic start_job(input logic [2:0] cfg, input logic [TmoW-1:0] tmo);
    bus.cfg_layers  = cfg;
    bus.cfg_timeout = tmo;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int when);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(bus.busy), 32'(0));
    when = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({bus.qkv_start, bus.qk_start, bus.mlp_start, bus.fb_sel, bus.capture,
                    bus.layer_idx, bus.busy, bus.done, bus.err, bus.err_stage}), 32'(0));
  endtask

  task automatic run_full(input logic [2:0] cfg, input int eff, input string tag);
    int t0, w;
    t0 = cyc;
    push_layers(t0, eff);
    start_job(cfg, '0);
    wait_idle(10 * eff + 20, w);
    check({tag, "_idle_cycle"}, 32'(w), 32'(t0 + 10 * eff + 1));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
    check({tag, "_err"}, 32'(bus.err), 32'(0));
  endtask

  initial begin
    int t0, w;
    cyc = 0; checks = 0; errors = 0;
    qkv_p = 1'b0; qk_p = 1'b0; mlp_p = 1'b0; hold_qk = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_layers = '0; bus.cfg_timeout = '0;
    bus.qkv_done = 1'b0; bus.qk_done = 1'b0; bus.mlp_done = 1'b0;

    // Reset state.
    #1 rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    tick();
    check_all_zero("after_release");

    // One layer: qkv_start c1, qk_start c3, mlp_start c8, capture+done c10, idle c11.
    run_full(3'd1, 1, "one_layer");

    // Three layers with stray dones from the wrong stage.
    t0 = cyc;
    push_layers(t0, 3);
    start_job(3'd3, '0);
    bus.qk_done = 1'b1;           // stray while in QKV
    tick();
    tick();
    bus.mlp_done = 1'b1;          // stray while in QK
    wait_idle(60, w);
    check("three_layer_idle_cycle", 32'(w), 32'(t0 + 31));
    check("three_layer_queue_empty", 32'(exp_q.size()), 32'(0));

    // Layer count clamping.
    run_full(3'd0, 1, "zero_layers");
    run_full(3'd7, 4, "clamp_layers");

    // Abort in MLP together with mlp_done; restarts while busy ignored.
    t0 = cyc;
    exp_q.push_back('{t0 + 1, 5'b10000, 2'd0, 1'b0});
    exp_q.push_back('{t0 + 3, 5'b01000, 2'd0, 1'b0});
    exp_q.push_back('{t0 + 8, 5'b00100, 2'd0, 1'b0});
    start_job(3'd2, '0);
    tick();
    bus.start = 1'b1; bus.cfg_layers = 3'd1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < t0 + 9) tick();
    check("abort_mlp_done_present", 32'(bus.mlp_done), 32'(1));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_err", 32'(bus.err), 32'(0));
    for (int i = 0; i < 12; i++) tick();
    check("abort_queue_empty", 32'(exp_q.size()), 32'(0));

    // Watchdog: qk_done never arrives.
    hold_qk = 1'b1;
    t0 = cyc;
    exp_q.push_back('{t0 + 1, 5'b10000, 2'd0, 1'b0});
    exp_q.push_back('{t0 + 3, 5'b01000, 2'd0, 1'b0});
    start_job(3'd1, 16'd5);
`ifdef ATTN_SEQ_WATCHDOG_EN
    begin
      int n;
      n = 0;
      while (bus.err !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
    end
    check("wdog_err", 32'(bus.err), 32'(1));
    check("wdog_err_stage", 32'(bus.err_stage), 32'(2));
    tick();
    check("wdog_idle", 32'(bus.busy), 32'(0));
    for (int i = 0; i < 5; i++) tick();
    check("wdog_err_sticky", 32'(bus.err), 32'(1));
    check("wdog_stage_sticky", 32'(bus.err_stage), 32'(2));
    check("wdog_queue_empty", 32'(exp_q.size()), 32'(0));
    hold_qk = 1'b0;
    t0 = cyc;
    push_layers(t0, 1);
    start_job(3'd1, '0);
    check("restart_err_cleared", 32'(bus.err), 32'(0));
    check("restart_stage_cleared", 32'(bus.err_stage), 32'(0));
    wait_idle(40, w);
    check("restart_idle_cycle", 32'(w), 32'(t0 + 11));
`else
    for (int i = 0; i < 30; i++) tick();
    check("nowdog_err", 32'(bus.err), 32'(0));
    check("nowdog_err_stage", 32'(bus.err_stage), 32'(0));
    check("nowdog_still_busy", 32'(bus.busy), 32'(1));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    hold_qk = 1'b0;
    check("nowdog_abort_idle", 32'(bus.busy), 32'(0));
    check("nowdog_queue_empty", 32'(exp_q.size()), 32'(0));
`endif

    // Reset asserted during SMX.
    t0 = cyc;
    push_layers(t0, 3);
    start_job(3'd3, '0);
    while (cyc < t0 + 5) tick();
    check("smx_reached_busy", 32'(bus.busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_smx");
    check("pending_at_reset", 32'(exp_q.size()), 32'(10));
    exp_q.delete();
    qkv_p = 1'b0; qk_p = 1'b0; mlp_p = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check_all_zero("after_reset_release");

    // Stray qk_done in IDLE.
    bus.qk_done = 1'b1;
    tick();
    check("stray_idle_busy", 32'(bus.busy), 32'(0));
    for (int i = 0; i < 3; i++) tick();
    check_all_zero("stray_idle_outputs");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/attention_sequencer.md
ATTENTION_SEQUENCER -- requirements
Module: attention_sequencer

Interface
REQ-001 SHALL have parameter MAX_LAYERS, default 4, maximum encoder layers run per job.
REQ-002 SHALL have parameter TMO_W, default 16, watchdog counter/config width.
REQ-003 SHALL have parameter SMX_CYC, default 2, fixed softmax+precision settle cycles (>=1).
REQ-004 SHALL derive LAYER_W = max(1, clog2(MAX_LAYERS)); not user-set.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  job request, sampled in IDLE only.
REQ-008 abort  in  1  cancel running job.
REQ-009 cfg_layers  in  LAYER_W+1  layers to run, latched at accepted start.
REQ-010 cfg_timeout  in  TMO_W  per-stage watchdog limit, latched at accepted start; 0 = watchdog off.
REQ-011 qkv_start / qk_start / mlp_start  out  1 each  single-cycle engine start pulses.
REQ-012 qkv_done / qk_done / mlp_done  in  1 each  engine completion.
REQ-013 fb_sel  out  1  engine input select: 0 external x, 1 previous-layer output buffer.
REQ-014 capture  out  1  pulse: load MLP output into layer buffer.
REQ-015 layer_idx  out  LAYER_W  current layer.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 done  out  1  single-cycle job-complete pulse.
REQ-018 err  out  1  sticky watchdog error; err_stage  out  2  stage code (1 QKV, 2 QK, 3 MLP, 0 none).

Function
REQ-019 States SHALL be IDLE, QKV, QK, SMX, AXV, MLP, LNEXT, DONE, ERR; all outputs registered.
REQ-020 IDLE + start: latch cfg, clear err/err_stage, layer_idx=0, fb_sel=0, enter QKV next cycle with qkv_start=1.
REQ-021 cfg_layers=0 SHALL be treated as 1; values > MAX_LAYERS clamped to MAX_LAYERS.
REQ-022 Start pulse SHALL be high only in first cycle of its stage; done inputs sampled only in matching stage, stray dones ignored.
REQ-023 QKV + qkv_done -> QK (qk_start pulse); QK + qk_done -> SMX.
REQ-024 SMX SHALL last exactly SMX_CYC cycles, then AXV exactly 1 cycle, then MLP (mlp_start pulse).
REQ-025 MLP + mlp_done, not last layer -> LNEXT one cycle: capture=1, layer_idx+1; then QKV with qkv_start=1, fb_sel=1.
REQ-026 MLP + mlp_done, last layer -> DONE one cycle: capture=1, done=1; then IDLE.
REQ-027 Zero-wait engines (done one cycle after start): done SHALL assert 10 cycles after start per layer (layer n: cycle 10n).
REQ-028 start while busy SHALL be ignored.
REQ-029 abort in any non-IDLE state -> IDLE next cycle, no start pulses, no done, no capture, err unchanged.
REQ-030 abort and engine done same cycle: abort wins.
REQ-031 Watchdog: counter cleared on entry to QKV/QK/MLP, increments each waiting cycle; reaching cfg_timeout without done -> ERR.
REQ-032 Done and watchdog expiry same cycle: done wins.
REQ-033 ERR one cycle: err=1, err_stage set; then IDLE; err stays high until next accepted start.

Reset
REQ-034 Reset SHALL force IDLE, all outputs 0 (busy, done, err, err_stage, layer_idx, fb_sel, capture, start pulses).
REQ-035 Reset mid-job SHALL take effect immediately, no completion pulses after release.

Configuration
REQ-036 Macro ATTN_SEQ_WATCHDOG_EN defined: REQ-031..033 watchdog active.
REQ-037 Macro undefined: no counter logic, stages wait indefinitely, err and err_stage tied 0, ERR unreachable.

Verification
REQ-038 cfg_layers=1, zero-wait engines, start cycle 0 -> qkv_start c1, qk_start c3, mlp_start c8, capture+done c10, busy low c11.
REQ-039 cfg_layers=3 -> capture at c10,c20,c30; layer_idx 0,1,2; fb_sel=1 from c11; single done at c30.
REQ-040 cfg_timeout=5, qk_done never -> err=1, err_stage=2, IDLE, no done; next start clears err.
REQ-041 abort in MLP same cycle as mlp_done -> IDLE next cycle, no capture/done; start twice while busy ignored.
REQ-042 cfg_layers=0 -> one layer; cfg_layers=7 with MAX_LAYERS=4 -> four captures.
REQ-043 rst_n low during SMX -> all outputs 0 immediately; stray qk_done in IDLE -> no effect.
